// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding two byte requesters into a single UART transmitter.
// The SEND state holds off new accepts for one full frame plus the stop guard.
//   state | meaning
//   IDLE  | arbitrating; ready is offered to the winning valid requester
//   SEND  | frame in flight; both readys low, counter runs down to zero
module uart_tx_arbiter #(
  parameter int BPS        = 'd9600,
  parameter int CLK_FRE    = 'd200_000_000,
  parameter int STOP_GUARD = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_en,
  output logic       busy,
  output logic       grant_id
);

  localparam int FRAME_CYCLES = (CLK_FRE / BPS) * (10 + STOP_GUARD);
  localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             rr_ptr;
  logic             winner;
  logic             xfer;

  // rr_ptr names the preferred requester; it only matters on a tie.
  always_comb begin
    winner = rr_ptr;
    if (req0_valid && !req1_valid) begin
      winner = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      winner = 1'b1;
    end
  end

  assign req0_ready = !sys_rst && (state == IDLE) && (winner == 1'b0) && req0_valid;
  assign req1_ready = !sys_rst && (state == IDLE) && (winner == 1'b1) && req1_valid;
  assign xfer       = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (xfer) state_next = SEND;
      SEND: if (cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_ptr       <= 1'b0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
      grant_id     <= 1'b0;
    end else begin
      state      <= state_next;
      uart_tx_en <= xfer;
      if (xfer) begin
        uart_tx_data <= winner ? req1_data : req0_data;
        grant_id     <= winner;
        rr_ptr       <= ~winner;
        cnt          <= CNT_LOAD;
      end else if ((state == SEND) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scenario tasks push expected bytes
// into a scoreboard that a monitor pops on every uart_tx_en pulse.
module tb_uart_tx_arbiter;

  localparam int FRAME = 110;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] uart_tx_data;
  logic       uart_tx_en;
  logic       busy;
  logic       grant_id;

  int tests_run;
  int tests_failed;
  logic [8:0] sb_q[$];

  uart_tx_arbiter #(
    .BPS(100_000),
    .CLK_FRE(1_000_000),
    .STOP_GUARD(1)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .req0_data(req0_data),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req1_data(req1_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .uart_tx_data(uart_tx_data),
    .uart_tx_en(uart_tx_en),
    .busy(busy),
    .grant_id(grant_id)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Every start pulse must match the oldest expected {grant_id, byte}.
  always @(negedge sys_clk) begin
    if (uart_tx_en === 1'b1) begin
      logic [8:0] exp;
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_pulse: got data=%02h id=%0d, required no pulse", uart_tx_data, grant_id);
      end else begin
        exp = sb_q.pop_front();
        if ({grant_id, uart_tx_data} !== exp) begin
          tests_failed++;
          $display("FAIL sb_pulse: got id=%0d data=%02h, required id=%0d data=%02h",
                   grant_id, uart_tx_data, exp[8], exp[7:0]);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    do begin
      @(negedge sys_clk);
      cycles++;
    end while (busy !== 1'b0 && cycles < 500);
  endtask

  task automatic apply_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sys_rst    = 1'b1;
    tick(2);
    sys_rst    = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst    = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'h3C;
    req1_data  = 8'hC3;
    tick(3);
    #1;
    tests_run++;
    if ({uart_tx_en, uart_tx_data, grant_id, busy} !== 11'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b data=%02h id=%b busy=%b, required all zero",
               uart_tx_en, uart_tx_data, grant_id, busy);
    end
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b%b, required 00", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sys_rst    = 1'b0;
    tick(2);
  endtask

  task automatic test_single();
    int c;
    apply_reset();
    req0_data  = 8'hA5;
    req0_valid = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_ready: got %b%b, required 10", req0_ready, req1_ready);
    end
    sb_q.push_back({1'b0, 8'hA5});
    tick(1);
    req0_valid = 1'b0;
    tests_run++;
    if ({uart_tx_en, uart_tx_data, busy, grant_id} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_t1: got en=%b data=%02h busy=%b id=%b, required 1 a5 1 0",
               uart_tx_en, uart_tx_data, busy, grant_id);
    end
    wait_idle(c);
    tests_run++;
    if (c + 1 !== FRAME + 1) begin
      tests_failed++;
      $display("FAIL single_busy_len: got busy low at T+%0d, required T+%0d", c + 1, FRAME + 1);
    end
  endtask

  task automatic test_round_robin();
    int c;
    logic exp_id[3] = '{1'b0, 1'b1, 1'b0};
    apply_reset();
    req0_data  = 8'h11;
    req1_data  = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== {~exp_id[i], exp_id[i]}) begin
        tests_failed++;
        $display("FAIL rr_ready[%0d]: got %b%b, required %b%b", i, req0_ready, req1_ready,
                 ~exp_id[i], exp_id[i]);
      end
      sb_q.push_back({exp_id[i], exp_id[i] ? 8'h22 : 8'h11});
      tick(1);
      if (i == 2) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        tests_failed++;
        $display("FAIL rr_send_ready[%0d]: got %b%b, required 00", i, req0_ready, req1_ready);
      end
      wait_idle(c);
      tests_run++;
      if (c + 1 !== FRAME + 1) begin
        tests_failed++;
        $display("FAIL rr_spacing[%0d]: got %0d, required %0d", i, c + 1, FRAME + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    req1_valid = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      req1_data = 8'(b);
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        tests_failed++;
        $display("FAIL b2b_ready[%0d]: got %b%b, required 01", b, req0_ready, req1_ready);
      end
      sb_q.push_back({1'b1, 8'(b)});
      tick(1);
      req1_data = 8'hEE;
      if (b == 3) req1_valid = 1'b0;
      tests_run++;
      if (grant_id !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_grant[%0d]: got %b, required 1", b, grant_id);
      end
      wait_idle(c);
      tests_run++;
      if (c + 1 !== FRAME + 1) begin
        tests_failed++;
        $display("FAIL b2b_spacing[%0d]: got %0d, required %0d", b, c + 1, FRAME + 1);
      end
    end
  endtask

  task automatic test_forfeit();
    int c;
    logic seen_ready;
    req1_data  = 8'h44;
    req1_valid = 1'b1;
    #1;
    sb_q.push_back({1'b1, 8'h44});
    tick(1);
    req1_valid = 1'b0;
    tick(20);
    req0_data  = 8'h99;
    req0_valid = 1'b1;
    seen_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (req0_ready !== 1'b0) seen_ready = 1'b1;
      tick(1);
    end
    req0_valid = 1'b0;
    tests_run++;
    if (seen_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL forfeit_ready: got ready=1 during SEND, required 0");
    end
    wait_idle(c);
    tick(20);
    tests_run++;
    if (sb_q.size() !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL forfeit_no_send: got pending=%0d busy=%b, required 0 0", sb_q.size(), busy);
    end
  endtask

  task automatic test_reset_abort();
    int c;
    req0_data  = 8'h5A;
    req0_valid = 1'b1;
    #1;
    sb_q.push_back({1'b0, 8'h5A});
    tick(1);
    req0_valid = 1'b0;
    tick(48);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    tests_run++;
    if ({busy, uart_tx_en, grant_id} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_state: got busy=%b en=%b id=%b, required 000", busy, uart_tx_en, grant_id);
    end
    tick(150);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: got busy=%b, required 0", busy);
    end
    req0_data  = 8'h66;
    req1_data  = 8'h77;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL abort_prefer_req0: got %b%b, required 10", req0_ready, req1_ready);
    end
    sb_q.push_back({1'b0, 8'h66});
    tick(1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle(c);
    tests_run++;
    if (c + 1 !== FRAME + 1) begin
      tests_failed++;
      $display("FAIL abort_next_frame: got %0d, required %0d", c + 1, FRAME + 1);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    sys_rst      = 1'b1;
    req0_valid   = 1'b0;
    req1_valid   = 1'b0;
    req0_data    = 8'h00;
    req1_data    = 8'h00;
    tick(1);
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_forfeit();
    test_reset_abort();
    tick(5);
    tests_run++;
    if (sb_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
